// File: rtl/gate_check_pkg.sv
// Shared definitions for the gate response checker: FSM state encoding and
// truth-table constants for common 2-input gates (bit index = {y, x}).
package gate_check_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_NAND = 4'b0111;

endpackage

// File: rtl/gate_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; it stops at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  // Count up on inc, hold at the maximum value, clear on rst or clr
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/gate_response_checker.sv
// Response checker for a gate under test: compares each accepted DUT output
// against a truth table and counts vectors and mismatches over a run of N_VEC
// accepts. Optional feature macro: CHECK_FIRST_FAIL_EN adds first_fail_vec and
// first_fail_idx, which record the first mismatching vector of the run.
module gate_response_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN  = 2,
  parameter logic [(1<<N_IN)-1:0]  TRUTH = TT_AND,
  parameter int                    N_VEC = 4,
  parameter int                    CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N_IN-1:0]  in_vec,
  input  logic             in_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] fail_cnt
`ifdef CHECK_FIRST_FAIL_EN
  ,
  output logic [N_IN-1:0]  first_fail_vec,
  output logic [CNT_W-1:0] first_fail_idx
`endif
);

  // Run-length counter is sized from N_VEC so completion does not depend on
  // the (possibly narrow, saturating) user-visible vec_cnt.
  localparam int AW = $clog2(N_VEC + 1);

  state_t          state;
  state_t          nextState;
  logic            startRun;
  logic            accept;
  logic            expectedBit;
  logic            mismatch;
  logic            lastAccept;
  logic [AW-1:0]   acceptCount;

  assign accept      = in_valid & in_ready;
  assign expectedBit = TRUTH[in_vec];
  assign mismatch    = (in_out != expectedBit);
  assign lastAccept  = (acceptCount == AW'(N_VEC - 1));

  // State register; reset always returns to IDLE
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic plus the state-decoded handshake and busy outputs
  always_comb begin
    nextState = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    startRun  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          nextState = RUN;
          startRun  = 1'b1;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && lastAccept) begin
          nextState = DONE;
        end
      end
      DONE: begin
        if (start) begin
          nextState = RUN;
          startRun  = 1'b1;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Internal accept counter that decides when the run is complete
  always_ff @(posedge clk) begin
    if (rst || startRun) begin
      acceptCount <= '0;
    end else if (accept) begin
      acceptCount <= acceptCount + AW'(1);
    end
  end

  // Registered completion flags; pass folds in the final vector's own result
  always_ff @(posedge clk) begin
    if (rst || startRun) begin
      done <= 1'b0;
      pass <= 1'b0;
    end else if (accept && lastAccept) begin
      done <= 1'b1;
      pass <= !mismatch && (fail_cnt == '0);
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_vec_cnt (
    .clk (clk),
    .rst (rst),
    .clr (startRun),
    .inc (accept),
    .q   (vec_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_fail_cnt (
    .clk (clk),
    .rst (rst),
    .clr (startRun),
    .inc (accept && mismatch),
    .q   (fail_cnt)
  );

`ifdef CHECK_FIRST_FAIL_EN
  logic firstFailSeen;

  // Capture the first mismatching vector and its position once per run
  always_ff @(posedge clk) begin
    if (rst || startRun) begin
      firstFailSeen  <= 1'b0;
      first_fail_vec <= '0;
      first_fail_idx <= '0;
    end else if (accept && mismatch && !firstFailSeen) begin
      firstFailSeen  <= 1'b1;
      first_fail_vec <= in_vec;
      first_fail_idx <= vec_cnt;
    end
  end
`endif

endmodule
